// File: rtl/fetch_pkg.sv
// Shared types and constant tables for the fetch stage: state enum, program
// start addresses, branch target table and default halt encoding.
package fetch_pkg;

  localparam int FETCH_A = 10;
  localparam int FETCH_W = 9;

  localparam logic [FETCH_W-1:0] FETCH_HALT_WORD = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [FETCH_A-1:0] PROG_START [4] = '{
    10'd0, 10'd256, 10'd512, 10'd768
  };

  localparam logic [FETCH_A-1:0] BR_TARGET [8] = '{
    10'd0, 10'd8, 10'd16, 10'd32, 10'd64, 10'd128, 10'd256, 10'd512
  };

  function automatic logic [FETCH_A-1:0] prog_start_addr(input logic [1:0] sel);
    return PROG_START[sel];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target lookup: 3-bit index to absolute A-bit address.
// Kept standalone so an assembler-generated table can replace it.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int A = FETCH_A
) (
  input  logic [2:0]   i_idx,
  output logic [A-1:0] o_target
);

  logic [A-1:0] w_table [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tbl
      assign w_table[gi] = A'(BR_TARGET[gi]);
    end
  endgenerate

  assign o_target = w_table[i_idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer (IDLE/ARMED/RUN/HALT) in front of a
// combinational instruction ROM. Optional run-cycle counter: FETCH_CYCLE_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            A         = FETCH_A,
  parameter int            W         = FETCH_W,
  parameter logic [W-1:0]  HALT_WORD = {W{1'b1}}
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   ProgSel,
  input  logic [W-1:0] InstOut,
  input  logic         BranchEn,
  input  logic [2:0]   TargetIdx,
  output logic [A-1:0] InstAddress,
  output logic         InstValid,
  output logic         Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]  CycleCount
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [A-1:0] r_pc;
  logic [A-1:0] w_pc_next;
  logic         r_done;
  logic         w_done_next;

  logic [A-1:0] w_start_addr;
  logic [A-1:0] w_br_target;
  logic         w_is_halt;

  assign w_start_addr = A'(prog_start_addr(ProgSel));
  assign w_is_halt    = (InstOut == HALT_WORD);

  branch_lut #(
    .A (A)
  ) u_branch_lut (
    .i_idx    (TargetIdx),
    .o_target (w_br_target)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_done  <= w_done_next;
    end
  end

  // Start overrides every state, including RUN (abort) and HALT (restart).
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_done_next  = r_done;
    if (Start) begin
      w_state_next = ST_ARMED;
      w_pc_next    = w_start_addr;
      w_done_next  = 1'b0;
    end else begin
      case (r_state)
        ST_ARMED: w_state_next = ST_RUN;
        ST_RUN: begin
          if (w_is_halt) begin
            w_state_next = ST_HALT;
            w_done_next  = 1'b1;
          end else if (BranchEn) begin
            w_pc_next = w_br_target;
          end else begin
            w_pc_next = r_pc + A'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign InstAddress = r_pc;
  assign Done        = r_done;
  // High on the halt-detect cycle too; decode must not treat HALT_WORD as an opcode.
  assign InstValid   = (r_state == ST_RUN);

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || (r_state == ST_ARMED)) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == ST_RUN) && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign CycleCount = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural model
// of program loading, sequential fetch, branching and halt.
module tb_fetch_unit;

  localparam int A = 10;
  localparam int W = 9;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   ProgSel;
  logic [W-1:0] InstOut;
  logic         BranchEn;
  logic [2:0]   TargetIdx;
  logic [A-1:0] InstAddress;
  logic         InstValid;
  logic         Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0]  CycleCount;
`endif

  fetch_unit #(.A(A), .W(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ProgSel     (ProgSel),
    .InstOut     (InstOut),
    .BranchEn    (BranchEn),
    .TargetIdx   (TargetIdx),
    .InstAddress (InstAddress),
    .InstValid   (InstValid),
    .Done        (Done)
`ifdef FETCH_CYCLE_CNT_EN
    ,
    .CycleCount  (CycleCount)
`endif
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: program phase as plain flags, pc as an integer address.
  bit m_loaded;   // a program has been selected (Start seen)
  bit m_running;  // fetching instructions
  bit m_halted;
  int m_pc;
  bit m_done;
  int m_cnt;

  function automatic int target_of(input int idx);
    return (idx == 0) ? 0 : (1 << (idx + 2));
  endfunction

  task automatic model_step();
    bit was_armed;
    bit was_running;
    was_armed   = m_loaded && !m_running && !m_halted;
    was_running = m_running;
    if (Reset) begin
      m_loaded = 0; m_running = 0; m_halted = 0;
      m_pc = 0; m_done = 0; m_cnt = 0;
    end else begin
      if (was_armed) m_cnt = 0;
      else if (was_running && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (Start) begin
        m_loaded = 1; m_running = 0; m_halted = 0;
        m_pc = int'(ProgSel) * 256;
        m_done = 0;
      end else if (was_armed) begin
        m_running = 1;
      end else if (was_running) begin
        if (InstOut == 9'h1FF) begin
          m_running = 0; m_halted = 1; m_done = 1;
        end else if (BranchEn) begin
          m_pc = target_of(int'(TargetIdx));
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input bit rst, input bit st, input int sel,
                       input int inst, input bit br, input int idx);
    Reset     = rst;
    Start     = st;
    ProgSel   = 2'(sel);
    InstOut   = 9'(inst);
    BranchEn  = br;
    TargetIdx = 3'(idx);
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check({tag, ".pc"},    int'(InstAddress), m_pc);
    check({tag, ".valid"}, int'(InstValid),   int'(m_running));
    check({tag, ".done"},  int'(Done),        int'(m_done));
`ifdef FETCH_CYCLE_CNT_EN
    check({tag, ".cnt"},   int'(CycleCount),  m_cnt);
`endif
    $display("%-8s pc=%0d valid=%0b done=%0b", tag, InstAddress, InstValid, Done);
  endtask

  function automatic int nonhalt();
    return int'($urandom_range(0, 510));
  endfunction

  initial begin
    // Reset dominates a held Start.
    drive(1, 1, 0, 0, 0, 0);
    tick("rst0");
    tick("rst1");
    drive(0, 1, 0, 0, 0, 0);
    tick("arm0");

    // Load program 2, hold Start, then run sequentially.
    drive(0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("load2");
    drive(0, 0, 2, nonhalt(), 0, 0);
    tick("go");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2, nonhalt(), 0, 0);
      tick("seq");
    end

    // Branch to 16, step to 20, then branch idx 3 -> 32.
    drive(0, 0, 2, nonhalt(), 1, 2);
    tick("br16");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2, nonhalt(), 0, 0);
      tick("to20");
    end
    drive(0, 0, 2, nonhalt(), 1, 3);
    tick("br32");

    // Back to 20, then halt word with BranchEn: halt wins.
    drive(0, 0, 2, nonhalt(), 1, 2);
    tick("br16b");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2, nonhalt(), 0, 0);
      tick("to20b");
    end
    drive(0, 0, 2, 9'h1FF, 1, 5);
    tick("halt");
    drive(0, 0, 2, nonhalt(), 1, 7);
    tick("hold");
    tick("hold");

    // Reset in HALT.
    drive(1, 0, 0, 0, 0, 0);
    tick("rsthlt");

    // Program 3 runs through 1023 and wraps to 0.
    drive(0, 1, 3, 0, 0, 0);
    tick("load3");
    drive(0, 0, 3, 0, 0, 0);
    tick("go3");
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 3, nonhalt(), 0, 0);
      tick("wrap");
    end

    // Program 2 to PC 700, then abort via Start with ProgSel 1.
    drive(0, 1, 2, 0, 0, 0);
    tick("load2b");
    drive(0, 0, 2, 0, 0, 0);
    tick("go2b");
    for (int i = 0; i < 188; i++) begin
      drive(0, 0, 2, nonhalt(), 0, 0);
      tick("to700");
    end
    drive(0, 1, 1, nonhalt(), 0, 0);
    tick("abort");

    // Five ordinary words then halt; restart afterwards.
    drive(0, 0, 1, 0, 0, 0);
    tick("go1");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, nonhalt(), 0, 0);
      tick("five");
    end
    drive(0, 0, 1, 9'h1FF, 0, 0);
    tick("halt6");
    drive(0, 0, 1, nonhalt(), 0, 0);
    tick("hold6");
    drive(0, 1, 0, 0, 0, 0);
    tick("restart");
    tick("armclr");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 29) == 0) ? 9'h1FF : nonhalt(),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
